// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS core constants, fetch FSM state type and instruction width.
// Contents: INSTR_W, major opcode constants, fetch_state_e (S_FAULT exists only with FETCH_ALIGN_CHECK_EN).
package mips_pkg;
   localparam int INSTR_W = 32;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
`ifdef FETCH_ALIGN_CHECK_EN
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_FAULT} fetch_state_e;
`else
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} fetch_state_e;
`endif
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational successor PC from the held instruction and decoder/ALU controls.
// Ports: pc, instr (held word), branch, jump, zero (ALU) -> next_pc. Jump beats branch; all math mod 2^32.
module next_pc_calc
   import mips_pkg::*;
(
   input  logic [31:0]        pc,
   input  logic [INSTR_W-1:0] instr,
   input  logic               branch,
   input  logic               jump,
   input  logic               zero,
   output logic [31:0]        next_pc
);
   logic [31:0] pc4;
   always_comb begin
      pc4     = pc + 32'd4;
      next_pc = jump ? {pc4[31:28], instr[25:0], 2'b00} :
                (branch & zero) ? pc4 + {{14{instr[15]}}, instr[15:0], 2'b00} : pc4;
   end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction fetch stage; holds PC, fetches over valid/ready, retires on instr_ack.
// Ports: clk, rst_n (async, active-low); imem_req_valid/ready/addr, imem_rsp_valid/data;
//        pc, instr, opcode, instr_valid, instr_ack; branch, jump, zero; retired_cnt, fetch_fault.
// Option: FETCH_ALIGN_CHECK_EN traps misaligned PCs in a sticky FAULT state; without it the
//         low PC bits are forced to zero and fetch_fault is tied low.
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [31:0]        imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   output logic [31:0]        pc,
   output logic [INSTR_W-1:0] instr,
   output logic [5:0]         opcode,
   output logic               instr_valid,
   input  logic               instr_ack,
   input  logic               branch,
   input  logic               jump,
   input  logic               zero,
   output logic [CNT_W-1:0]   retired_cnt,
   output logic               fetch_fault
);
   fetch_state_e state, state_nx;
   logic [31:0] npc_raw, npc;
   next_pc_calc u_npc (
      .pc      (pc),
      .instr   (instr),
      .branch  (branch),
      .jump    (jump),
      .zero    (zero),
      .next_pc (npc_raw)
   );
`ifdef FETCH_ALIGN_CHECK_EN
   localparam logic [31:0] PC_INIT = RESET_PC;
   assign npc = npc_raw;
`else
   localparam logic [31:0] PC_INIT = RESET_PC & ~32'h3;
   assign npc = npc_raw & ~32'h3;
`endif
   assign imem_req_addr = pc;
   assign opcode        = instr[31:26];
   always_comb begin
      state_nx       = state;
      imem_req_valid = (state == S_REQ);
      instr_valid    = (state == S_HOLD);
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_fault    = (state == S_FAULT);
`else
      fetch_fault    = 1'b0;
`endif
      case (state)
`ifdef FETCH_ALIGN_CHECK_EN
         S_IDLE:  state_nx = (PC_INIT[1:0] != 2'b00) ? S_FAULT : S_REQ;
         S_HOLD:  state_nx = !instr_ack ? S_HOLD : (npc[1:0] != 2'b00) ? S_FAULT : S_REQ;
         S_FAULT: state_nx = S_FAULT;
`else
         S_IDLE:  state_nx = S_REQ;
         S_HOLD:  state_nx = instr_ack ? S_REQ : S_HOLD;
`endif
         S_REQ:   state_nx = imem_req_ready ? S_WAIT : S_REQ;
         S_WAIT:  state_nx = imem_rsp_valid ? S_HOLD : S_WAIT;
         default: state_nx = S_IDLE;
      endcase
   end
   // Response capture is gated by WAIT, so stale or same-cycle responses are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         pc          <= PC_INIT;
         instr       <= '0;
         retired_cnt <= '0;
      end else begin
         state <= state_nx;
         if (state == S_WAIT && imem_rsp_valid) instr <= imem_rsp_data;
         if (state == S_HOLD && instr_ack) begin
            pc          <= npc;
            retired_cnt <= retired_cnt + CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit; three instances in lockstep (RESET_PC 0, 0x40000000, 0x2).
module tb_fetch_unit;
   logic        clk = 0, rst_n = 0, req_ready = 0, rsp_valid = 0, ack = 0, branch = 0, jump = 0, zero = 0;
   logic [31:0] rsp_data = 0;
   logic        a_rv, b_rv, c_rv, a_iv, b_iv, c_iv, a_ff, b_ff, c_ff;
   logic [31:0] a_addr, b_addr, c_addr, a_pc, b_pc, c_pc, a_instr, b_instr, c_instr, a_cnt, b_cnt, c_cnt;
   logic [5:0]  a_op, b_op, c_op;
   int          checks = 0, errors = 0;
   always #5 clk = ~clk;
   fetch_unit #(.RESET_PC(32'h0000_0000)) dut_a (
      .clk(clk), .rst_n(rst_n), .imem_req_valid(a_rv), .imem_req_ready(req_ready), .imem_req_addr(a_addr),
      .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data), .pc(a_pc), .instr(a_instr), .opcode(a_op),
      .instr_valid(a_iv), .instr_ack(ack), .branch(branch), .jump(jump), .zero(zero),
      .retired_cnt(a_cnt), .fetch_fault(a_ff));
   fetch_unit #(.RESET_PC(32'h4000_0000)) dut_b (
      .clk(clk), .rst_n(rst_n), .imem_req_valid(b_rv), .imem_req_ready(req_ready), .imem_req_addr(b_addr),
      .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data), .pc(b_pc), .instr(b_instr), .opcode(b_op),
      .instr_valid(b_iv), .instr_ack(ack), .branch(branch), .jump(jump), .zero(zero),
      .retired_cnt(b_cnt), .fetch_fault(b_ff));
   fetch_unit #(.RESET_PC(32'h0000_0002)) dut_c (
      .clk(clk), .rst_n(rst_n), .imem_req_valid(c_rv), .imem_req_ready(req_ready), .imem_req_addr(c_addr),
      .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data), .pc(c_pc), .instr(c_instr), .opcode(c_op),
      .instr_valid(c_iv), .instr_ack(ack), .branch(branch), .jump(jump), .zero(zero),
      .retired_cnt(c_cnt), .fetch_fault(c_ff));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic do_fetch(input logic [31:0] word, input logic [31:0] addr, input bit early);
      chk("req_valid", 32'(a_rv), 1);
      chk("req_addr", a_addr, addr);
      req_ready = 1;
      if (early) begin
         rsp_valid = 1;
         rsp_data  = 32'hBAD0_BAD0;
      end
      tick;
      req_ready = 0;
      rsp_valid = 1;
      rsp_data  = word;
      chk("wait_instr_valid", 32'(a_iv), 0);
      chk("wait_req_valid", 32'(a_rv), 0);
      tick;
      rsp_valid = 0;
      chk("hold_instr_valid", 32'(a_iv), 1);
      chk("hold_instr", a_instr, word);
   endtask
   task automatic retire(input bit br, input bit jp, input bit z, input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
      branch = br;
      jump   = jp;
      zero   = z;
      ack    = 1;
      tick;
      ack    = 0;
      branch = 0;
      jump   = 0;
      zero   = 0;
      chk("retire_instr_valid", 32'(a_iv), 0);
      chk("retire_pc", a_pc, exp_pc);
      chk("retire_cnt", a_cnt, exp_cnt);
      chk("retire_req_valid", 32'(a_rv), 1);
   endtask
   initial begin
      repeat (2) tick;
      chk("rst_pc", a_pc, 0);
      chk("rst_instr", a_instr, 0);
      chk("rst_instr_valid", 32'(a_iv), 0);
      chk("rst_req_valid", 32'(a_rv), 0);
      chk("rst_cnt", a_cnt, 0);
      chk("rst_fault", 32'(a_ff), 0);
      chk("rst_pc_hi", b_pc, 32'h4000_0000);
      rst_n = 1;
      chk("idle_req_valid", 32'(a_rv), 0);
      tick;
      chk("req_after_idle", 32'(a_rv), 1);
`ifdef FETCH_ALIGN_CHECK_EN
      chk("mis_fault", 32'(c_ff), 1);
      chk("mis_no_req", 32'(c_rv), 0);
`else
      chk("mis_req_valid", 32'(c_rv), 1);
      chk("mis_req_addr", c_addr, 0);
      chk("mis_fault", 32'(c_ff), 0);
`endif
      rsp_valid = 1;
      rsp_data  = 32'h1234_5678;
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("stall_req_valid", 32'(a_rv), 1);
         chk("stall_addr", a_addr, 0);
         chk("stall_instr_valid", 32'(a_iv), 0);
      end
      rsp_valid = 0;
      ack = 1;
      tick;
      ack = 0;
      chk("ack_in_req_pc", a_pc, 0);
      chk("ack_in_req_cnt", a_cnt, 0);
      do_fetch(32'h2008_0005, 32'h0, 1);
      chk("addi_opcode", 32'(a_op), 32'h08);
      tick;
      chk("hold_stable_valid", 32'(a_iv), 1);
      chk("hold_stable_instr", a_instr, 32'h2008_0005);
      retire(0, 0, 0, 32'h4, 1);
      for (int k = 1; k < 4; k++) begin
         do_fetch(32'h0, 32'(4 * k), 0);
         retire(0, 0, 0, 32'(4 * k + 4), 32'(k + 1));
      end
      do_fetch(32'h1000_FFFF, 32'h10, 0);
      chk("beq_opcode", 32'(a_op), 32'h04);
      retire(1, 0, 1, 32'h10, 5);
      do_fetch(32'h1000_FFFF, 32'h10, 0);
      retire(1, 0, 0, 32'h14, 6);
      chk("pre_reset_req", 32'(a_rv), 1);
      req_ready = 1;
      tick;
      req_ready = 0;
      rst_n = 0;
      #2;
      chk("midrst_pc", a_pc, 0);
      chk("midrst_instr_valid", 32'(a_iv), 0);
      chk("midrst_req_valid", 32'(a_rv), 0);
      chk("midrst_cnt", a_cnt, 0);
      tick;
      rst_n = 1;
      rsp_valid = 1;
      rsp_data  = 32'hDEAD_BEEF;
      tick;
      tick;
      rsp_valid = 0;
      chk("stale_instr_valid", 32'(a_iv), 0);
      chk("stale_instr", a_instr, 0);
      chk("stale_req_valid", 32'(a_rv), 1);
      chk("stale_req_addr", a_addr, 0);
      chk("hi_req_addr", b_addr, 32'h4000_0000);
      do_fetch(32'h0800_0040, 32'h0, 0);
      chk("j_opcode", 32'(a_op), 32'h02);
      retire(1, 1, 1, 32'h100, 1);
      chk("hi_jump_pc", b_pc, 32'h4000_0100);
      chk("hi_jump_cnt", b_cnt, 1);
`ifdef FETCH_ALIGN_CHECK_EN
      chk("mis_fault_end", 32'(c_ff), 1);
      chk("mis_no_req_end", 32'(c_rv), 0);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
